cpu_step_ctrl: RTL and testbench

- Sits directly downstream of the clock divider on the single-cycle CPU FPGA board.
- Runs on the fast board clock and samples the divider's slow square wave, then turns each rising edge into a one-cycle CPU clock-enable pulse.
- Gates those pulses with run/pause, a debounced single-step button and a CPU halt request.
- Also counts the CPU cycles it has issued, for the display logic.

---
 rtl/cpu_step_ctrl.sv | 176 +++++++++++++++++
 tb/tb_cpu_step_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_step_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_step_ctrl
//
// Turns the clock divider's slow square wave into single-cycle CPU clock-enable
// pulses on the fast board clock. The pulses are gated by a run/pause switch, a
// debounced single-step button and a CPU halt request. The block also counts
// the pulses it has issued so the display logic can show them.
//
// Handshake: none. cpu_en is a plain one-cycle strobe with no back-pressure.
// Every rising edge of slow_clk seen while the controller allows it produces
// exactly one cpu_en cycle. An edge that arrives while the pulse is not
// allowed is dropped.
//
// Ports
//   clk_in   : board clock. This is the only clock in the block.
//   rst      : asynchronous, active-high reset.
//   slow_clk : divided square wave. Asynchronous, so it is synchronized here.
//   run_sw   : 1 = free-run, 0 = pause. Asynchronous.
//   step_btn : single-step push button. Active-high, bouncy, asynchronous.
//   halt     : halt request from the CPU. Synchronous to clk_in.
//   cpu_en   : one-cycle CPU clock-enable pulse (registered).
//   mode     : controller state. 00 PAUSE, 01 RUN, 10 STEP, 11 HALT.
//              This also serves as the state debug view.
//   step_cnt : number of cpu_en pulses since reset. Saturates at all-ones.
// -----------------------------------------------------------------------------
module cpu_step_ctrl #(
    parameter logic [15:0] DEB_CYCLES = 16'd50000,
    parameter int          CNT_W      = 16
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             slow_clk,
    input  logic             run_sw,
    input  logic             step_btn,
    input  logic             halt,
    output logic             cpu_en,
    output logic [1:0]       mode,
    output logic [CNT_W-1:0] step_cnt
);

    localparam logic [1:0] ST_PAUSE = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_STEP  = 2'b10;
    localparam logic [1:0] ST_HALT  = 2'b11;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [15:0]      DEB_LAST = DEB_CYCLES - 16'd1;

    // slow_clk synchronizer plus a third flop for edge detection.
    logic slow_s1, slow_s2, slow_s3;
    // Two-flop synchronizers for the switch and the button.
    logic run_s1, run_s;
    logic btn_s1, btn_s;

    // Debounce state.
    logic [15:0] deb_cnt;
    logic        btn_lvl;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic        cpu_en_nxt;

    logic        rise;
    logic        deb_diff;
    logic        deb_done;
    logic        step_press;

    // -------------------------------------------------------------------------
    // Input synchronizers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            slow_s1 <= 1'b0;
            slow_s2 <= 1'b0;
            slow_s3 <= 1'b0;
            run_s1  <= 1'b0;
            run_s   <= 1'b0;
            btn_s1  <= 1'b0;
            btn_s   <= 1'b0;
        end else begin
            slow_s1 <= slow_clk;
            slow_s2 <= slow_s1;
            slow_s3 <= slow_s2;
            run_s1  <= run_sw;
            run_s   <= run_s1;
            btn_s1  <= step_btn;
            btn_s   <= btn_s1;
        end
    end

    assign rise = slow_s2 & ~slow_s3;

    // -------------------------------------------------------------------------
    // Button debounce
    // -------------------------------------------------------------------------
    // deb_cnt counts the consecutive cycles in which btn_s has disagreed with
    // the accepted level. The flip happens on the DEB_CYCLES-th such cycle,
    // which is when the count already stands at DEB_CYCLES-1.
    assign deb_diff   = (btn_s != btn_lvl);
    assign deb_done   = deb_diff && (deb_cnt == DEB_LAST);
    // A press is the cycle in which the accepted level goes from 0 to 1.
    assign step_press = deb_done && !btn_lvl;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            deb_cnt <= 16'd0;
            btn_lvl <= 1'b0;
        end else if (!deb_diff) begin
            deb_cnt <= 16'd0;
        end else if (deb_done) begin
            deb_cnt <= 16'd0;
            btn_lvl <= ~btn_lvl;
        end else begin
            deb_cnt <= deb_cnt + 16'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Run/step/halt state machine
    // -------------------------------------------------------------------------
    // In every state halt has top priority. HALT is left only through reset.
    always_comb begin
        state_nxt  = state;
        cpu_en_nxt = 1'b0;
        case (state)
            ST_PAUSE: begin
                if (halt)            state_nxt = ST_HALT;
                else if (run_s)      state_nxt = ST_RUN;
                else if (step_press) state_nxt = ST_STEP;
            end
            ST_RUN: begin
                // A run_s drop that coincides with a rise drops that rise.
                if (halt)        state_nxt = ST_HALT;
                else if (!run_s) state_nxt = ST_PAUSE;
                else             cpu_en_nxt = rise;
            end
            ST_STEP: begin
                // run_s and further presses are ignored until the pulse issues.
                if (halt) begin
                    state_nxt = ST_HALT;
                end else if (rise) begin
                    cpu_en_nxt = 1'b1;
                    state_nxt  = ST_PAUSE;
                end
            end
            default: begin
                state_nxt = ST_HALT;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state  <= ST_PAUSE;
            cpu_en <= 1'b0;
        end else begin
            state  <= state_nxt;
            cpu_en <= cpu_en_nxt;
        end
    end

    assign mode = state;

    // -------------------------------------------------------------------------
    // Issued-cycle counter (saturating)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            step_cnt <= {CNT_W{1'b0}};
        end else if (cpu_en && (step_cnt != CNT_MAX)) begin
            step_cnt <= step_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cpu_step_ctrl
//
// This bench drives two instances with the same inputs. Both use DEB_CYCLES = 4.
// The main instance has a 16-bit counter and the second has a 3-bit counter, so
// that the saturating count can be observed. slow_clk has a period of 20
// clk_in cycles and can be frozen low.
//
// The reference model follows the behaviour rules from the sampled input
// history. It records the cycle of every expected cpu_en pulse in a queue. A
// separate monitor runs 1 time unit after each rising edge and compares the
// DUT outputs with the model.
// -----------------------------------------------------------------------------
module tb_cpu_step_ctrl;

    localparam int DEB = 4;
    localparam int SAT_MAX = 7;

    localparam int M_PAUSE = 0;
    localparam int M_RUN   = 1;
    localparam int M_STEP  = 2;
    localparam int M_HALT  = 3;

    logic        clk_in = 1'b0;
    logic        rst = 1'b1;
    logic        slow_clk = 1'b0;
    logic        run_sw = 1'b0;
    logic        step_btn = 1'b0;
    logic        halt = 1'b0;

    logic        cpu_en, cpu_en_sat;
    logic [1:0]  mode, mode_sat;
    logic [15:0] step_cnt;
    logic [2:0]  step_cnt_sat;

    int vectors = 0;
    int miscompares = 0;

    // ---------------------------------------------------------------- clock
    always #5 clk_in = ~clk_in;

    cpu_step_ctrl #(.DEB_CYCLES(16'd4), .CNT_W(16)) dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .slow_clk (slow_clk),
        .run_sw   (run_sw),
        .step_btn (step_btn),
        .halt     (halt),
        .cpu_en   (cpu_en),
        .mode     (mode),
        .step_cnt (step_cnt)
    );

    cpu_step_ctrl #(.DEB_CYCLES(16'd4), .CNT_W(3)) dut_sat (
        .clk_in   (clk_in),
        .rst      (rst),
        .slow_clk (slow_clk),
        .run_sw   (run_sw),
        .step_btn (step_btn),
        .halt     (halt),
        .cpu_en   (cpu_en_sat),
        .mode     (mode_sat),
        .step_cnt (step_cnt_sat)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------ reference model
    // The h_* arrays hold the inputs seen at previous rising edges.
    // Index d is the value sampled d edges ago.
    logic [31:0] exp_q[$];
    logic [31:0] cyc = 32'd0;
    bit h_slow[1:3];
    bit h_run[1:2];
    bit h_btn[1:2];
    int m_mode = M_PAUSE;
    bit m_en = 1'b0;
    int m_cnt = 0;
    bit acc = 1'b0;
    int run_len = 0;

    always @(posedge clk_in) begin
        bit m_rise, m_run, m_btn, m_press;
        cyc = cyc + 32'd1;
        if (rst) begin
            m_mode = M_PAUSE;
            m_en = 1'b0;
            m_cnt = 0;
            acc = 1'b0;
            run_len = 0;
            for (int i = 1; i <= 3; i++) h_slow[i] = 1'b0;
            for (int i = 1; i <= 2; i++) begin
                h_run[i] = 1'b0;
                h_btn[i] = 1'b0;
            end
            exp_q.delete();
        end else begin
            // The pulse issued at the previous edge is counted at this edge.
            if (m_en) m_cnt++;
            m_rise = h_slow[2] && !h_slow[3];
            m_run  = h_run[2];
            m_btn  = h_btn[2];
            // The accepted level changes after DEB consecutive disagreeing cycles.
            m_press = 1'b0;
            if (m_btn != acc) begin
                run_len++;
                if (run_len == DEB) begin
                    acc = m_btn;
                    run_len = 0;
                    m_press = m_btn;
                end
            end else begin
                run_len = 0;
            end
            m_en = 1'b0;
            if (m_mode != M_HALT && halt) begin
                m_mode = M_HALT;
            end else begin
                case (m_mode)
                    M_PAUSE: if (m_run) m_mode = M_RUN; else if (m_press) m_mode = M_STEP;
                    M_RUN:   if (!m_run) m_mode = M_PAUSE; else m_en = m_rise;
                    M_STEP:  if (m_rise) begin m_en = 1'b1; m_mode = M_PAUSE; end
                    default: m_mode = M_HALT;
                endcase
            end
            if (m_en) exp_q.push_back(cyc);
            h_slow[3] = h_slow[2]; h_slow[2] = h_slow[1]; h_slow[1] = slow_clk;
            h_run[2] = h_run[1];   h_run[1] = run_sw;
            h_btn[2] = h_btn[1];   h_btn[1] = step_btn;
        end
    end

    // ---------------------------------------------------------------- monitor
    initial begin
        logic [31:0] e;
        forever begin
            @(posedge clk_in);
            #1;
            check("mode", {30'd0, mode}, m_mode);
            check("mode_sat", {30'd0, mode_sat}, m_mode);
            check("step_cnt", {16'd0, step_cnt}, m_cnt);
            check("step_cnt_sat", {29'd0, step_cnt_sat}, (m_cnt > SAT_MAX) ? SAT_MAX : m_cnt);
            check("cpu_en_sat", {31'd0, cpu_en_sat}, {31'd0, cpu_en});
            vectors++;
            if (cpu_en) begin
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL pulse: got unexpected cpu_en at cycle %0d, expected none", cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (e != cyc) begin
                        miscompares++;
                        $display("FAIL pulse_time: got cpu_en at cycle %0d, expected at %0d", cyc, e);
                    end
                end
            end else if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                miscompares++;
                $display("FAIL pulse_missing: got cpu_en=0 at cycle %0d, expected pulse at %0d", cyc, e);
            end
        end
    end

    // ---------------------------------------------------------------- drivers
    int  ph = 0;
    bit  slow_on = 1'b1;

    task automatic tick();
        @(negedge clk_in);
        if (slow_on) ph = (ph + 1) % 20;
        slow_clk = (ph >= 10);
    endtask

    task automatic tick_n(input int n);
        repeat (n) tick();
    endtask

    task automatic tick_to(input int p);
        do tick(); while (ph != p);
    endtask

    task automatic hold_btn(input bit v, input int n);
        step_btn = v;
        tick_n(n);
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        int act;
        // Reset state
        tick_n(3);
        check("rst_cpu_en", {31'd0, cpu_en}, 0);
        check("rst_mode", {30'd0, mode}, M_PAUSE);
        check("rst_step_cnt", {16'd0, step_cnt}, 0);
        rst = 1'b0;

        // Free run for 5 slow periods.
        tick_to(0);
        run_sw = 1'b1;
        tick_n(2);
        tick();
        check("run_mode", {30'd0, mode}, M_RUN);
        tick_n(97);
        run_sw = 1'b0;
        tick_n(25);
        check("run_cnt", {16'd0, step_cnt}, 5);
        check("run_end_mode", {30'd0, mode}, M_PAUSE);

        // Single step with a bouncing button. slow_clk is frozen low so that
        // the second press lands while the controller is still in STEP.
        slow_on = 1'b0;
        for (int i = 0; i < 6; i++) hold_btn(i[0] ? 1'b0 : 1'b1, 1);
        hold_btn(1'b1, 6);
        hold_btn(1'b0, 8);
        check("step_mode", {30'd0, mode}, M_STEP);
        hold_btn(1'b1, 8);
        hold_btn(1'b0, 8);
        check("step_mode_2nd", {30'd0, mode}, M_STEP);
        slow_on = 1'b1;
        tick_n(30);
        check("step_cnt", {16'd0, step_cnt}, 6);
        check("step_end_mode", {30'd0, mode}, M_PAUSE);

        // run_s falls in the same cycle as a rise.
        tick_to(12);
        run_sw = 1'b1;
        tick_to(10);
        run_sw = 1'b0;
        tick_n(5);
        check("race_mode", {30'd0, mode}, M_PAUSE);
        check("race_cnt", {16'd0, step_cnt}, 6);

        // Halt arrives in the same cycle as the fourth rise of a run.
        tick_to(0);
        run_sw = 1'b1;
        tick_n(72);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        tick_n(60);
        check("halt_mode", {30'd0, mode}, M_HALT);
        check("halt_cnt", {16'd0, step_cnt}, 9);
        check("sat_cnt", {29'd0, step_cnt_sat}, SAT_MAX);

        // Reset while activity is ongoing.
        rst = 1'b1;
        #1;
        check("rst2_mode", {30'd0, mode}, M_PAUSE);
        check("rst2_cnt", {16'd0, step_cnt}, 0);
        check("rst2_cpu_en", {31'd0, cpu_en}, 0);
        tick_n(3);
        rst = 1'b0;
        tick();
        check("rst2_first_cycle", {31'd0, cpu_en}, 0);
        run_sw = 1'b0;

        // Randomized phase.
        for (int it = 0; it < 60; it++) begin
            act = $urandom_range(0, 6);
            case (act)
                0, 1: begin
                    run_sw = 1'b1;
                    tick_n($urandom_range(3, 70));
                    run_sw = 1'b0;
                    tick_n($urandom_range(0, 10));
                end
                2, 3: begin
                    for (int i = 0; i < int'($urandom_range(0, 6)); i++)
                        hold_btn($urandom_range(0, 1) != 0, 1);
                    hold_btn(1'b1, $urandom_range(2, 8));
                    hold_btn(1'b0, $urandom_range(2, 8));
                    run_sw = ($urandom_range(0, 3) == 0);
                end
                4: tick_n($urandom_range(1, 30));
                5: begin
                    halt = 1'b1;
                    tick();
                    halt = 1'b0;
                    tick_n($urandom_range(5, 40));
                    rst = 1'b1;
                    tick_n($urandom_range(1, 3));
                    rst = 1'b0;
                end
                default: begin
                    rst = 1'b1;
                    tick();
                    rst = 1'b0;
                    tick_n($urandom_range(1, 20));
                end
            endcase
        end

        run_sw = 1'b0;
        step_btn = 1'b0;
        tick_n(30);
        check("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
